// File: rtl/tournament_pkg.sv
// Shared types, constants and the training function for the tournament choice counters.
// The selection mux uses the same constants for its global/local threshold.
package tournament_pkg;

  typedef logic [1:0] choice_t;

  localparam choice_t CHOICE_SLOCAL  = 2'd0;
  localparam choice_t CHOICE_WLOCAL  = 2'd1;
  localparam choice_t CHOICE_WGLOBAL = 2'd2;
  localparam choice_t CHOICE_SGLOBAL = 2'd3;
  localparam choice_t CHOICE_INIT    = CHOICE_WLOCAL;

  typedef enum logic {INIT, RUN} choice_state_e;

  // Move toward whichever component was right; no change when they agree.
  function automatic choice_t choice_train(input choice_t cur, input logic g_ok, input logic l_ok);
    choice_t nxt;
    nxt = cur;
    if (g_ok && !l_ok && cur != CHOICE_SGLOBAL) begin
      nxt = cur + 2'd1;
    end else if (l_ok && !g_ok && cur != CHOICE_SLOCAL) begin
      nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tournament_choice_ram.sv
// 1R1W synchronous array of choice counters; registered read returns the pre-write value.
// No reset: contents are written by the owner's init sweep.
module tournament_choice_ram
  import tournament_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  choice_t          wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output choice_t          rd_data
);

  choice_t mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/tournament_choice_table.sv
// Per-PC 2-bit choice counter table with self-initialising sweep, 1-cycle lookup,
// saturating training and write-to-read bypass.
module tournament_choice_table
  import tournament_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int PC_W    = 32,
  parameter int PC_LSB  = 2,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_v_i,
  input  logic [PC_W-1:0] lookup_pc_i,
  output logic            lookup_ready_o,
  output logic            choice_v_o,
  output choice_t         choice_o,
  input  logic            upd_v_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_global_correct_i,
  input  logic            upd_local_correct_i,
  output logic            upd_ready_o,
  output logic            init_done_o
);

  // Copy 0 serves lookups, copy 1 serves the training read; both get every write.
  localparam int NCOPY = 2;

  choice_state_e    state_reg, state_next;
  logic [IDX_W-1:0] init_idx_reg, init_idx_next;

  logic             run;
  logic             lookup_fire, upd_fire;
  logic [IDX_W-1:0] lookup_idx, upd_idx;

  logic             lk_v_reg;
  logic [IDX_W-1:0] lk_idx_reg;
  logic             tr_v_reg, tr_g_reg, tr_l_reg;
  logic [IDX_W-1:0] tr_idx_reg;
  logic             fwd_v_reg;
  logic [IDX_W-1:0] fwd_idx_reg;
  choice_t          fwd_val_reg;
  choice_t          choice_hold_reg;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  choice_t          wr_data;
  choice_t          tr_base, lk_val;
  logic [IDX_W-1:0] rd_idx  [NCOPY];
  choice_t          rd_data [NCOPY];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i, upd_pc_i};

  assign run            = (state_reg == RUN);
  assign lookup_ready_o = run;
  assign upd_ready_o    = run;
  assign init_done_o    = run;
  assign lookup_fire    = lookup_v_i & run;
  assign upd_fire       = upd_v_i & run;
  assign lookup_idx     = lookup_pc_i[PC_LSB +: IDX_W];
  assign upd_idx        = upd_pc_i[PC_LSB +: IDX_W];
  assign rd_idx[0]      = lookup_idx;
  assign rd_idx[1]      = upd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= INIT;
      init_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_idx_reg <= init_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_idx_next = init_idx_reg;
    if (state_reg == INIT) begin
      init_idx_next = init_idx_reg + IDX_W'(1);
      if (init_idx_reg == IDX_W'(ENTRIES - 1)) begin
        state_next = RUN;
      end
    end
  end

  for (genvar gi = 0; gi < NCOPY; gi++) begin : g_copy
    tournament_choice_ram #(
      .ENTRIES(ENTRIES),
      .IDX_W  (IDX_W)
    ) u_ram (
      .clk    (clk),
      .wr_en  (wr_en),
      .wr_idx (wr_idx),
      .wr_data(wr_data),
      .rd_idx (rd_idx[gi]),
      .rd_data(rd_data[gi])
    );
  end

  // Training read lands a cycle late, so the write retired on that same edge is forwarded.
  always_comb begin
    tr_base = rd_data[1];
    if (fwd_v_reg && fwd_idx_reg == tr_idx_reg) begin
      tr_base = fwd_val_reg;
    end
    wr_en   = tr_v_reg;
    wr_idx  = tr_idx_reg;
    wr_data = choice_train(tr_base, tr_g_reg, tr_l_reg);
    if (state_reg == INIT) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx_reg;
      wr_data = CHOICE_INIT;
    end
  end

  // Same-cycle update wins over the write that landed on the lookup's read edge.
  always_comb begin
    lk_val = rd_data[0];
    if (tr_v_reg && tr_idx_reg == lk_idx_reg) begin
      lk_val = wr_data;
    end else if (fwd_v_reg && fwd_idx_reg == lk_idx_reg) begin
      lk_val = fwd_val_reg;
    end
  end

  assign choice_v_o = lk_v_reg;
  assign choice_o   = lk_v_reg ? lk_val : choice_hold_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_v_reg        <= 1'b0;
      lk_idx_reg      <= '0;
      tr_v_reg        <= 1'b0;
      tr_idx_reg      <= '0;
      tr_g_reg        <= 1'b0;
      tr_l_reg        <= 1'b0;
      fwd_v_reg       <= 1'b0;
      fwd_idx_reg     <= '0;
      fwd_val_reg     <= CHOICE_INIT;
      choice_hold_reg <= CHOICE_INIT;
    end else begin
      lk_v_reg        <= lookup_fire;
      lk_idx_reg      <= lookup_idx;
      tr_v_reg        <= upd_fire;
      tr_idx_reg      <= upd_idx;
      tr_g_reg        <= upd_global_correct_i;
      tr_l_reg        <= upd_local_correct_i;
      fwd_v_reg       <= wr_en;
      fwd_idx_reg     <= wr_idx;
      fwd_val_reg     <= wr_data;
      choice_hold_reg <= choice_o;
    end
  end

endmodule

// File: tb/tb_tournament_choice_table.sv
// Bench for tournament_choice_table: per-cycle comparison against a table model plus
// directed lookups with hand-computed expected counters.
module tb_tournament_choice_table;

  logic        clk;
  logic        rst_n;
  logic        lookup_v;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        choice_v;
  logic [1:0]  choice;
  logic        upd_v;
  logic [31:0] upd_pc;
  logic        upd_g;
  logic        upd_l;
  logic        upd_ready;
  logic        init_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tournament_choice_table dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .lookup_v_i          (lookup_v),
    .lookup_pc_i         (lookup_pc),
    .lookup_ready_o      (lookup_ready),
    .choice_v_o          (choice_v),
    .choice_o            (choice),
    .upd_v_i             (upd_v),
    .upd_pc_i            (upd_pc),
    .upd_global_correct_i(upd_g),
    .upd_local_correct_i (upd_l),
    .upd_ready_o         (upd_ready),
    .init_done_o         (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a plain array of counters, readiness from a cycle count.
  int model_tbl [256];
  int init_cnt   = 0;
  int exp_ready  = 0;
  int exp_v      = 0;
  int exp_choice = 1;

  function automatic int pc_to_idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hFF);
  endfunction

  task automatic model_step();
    int ui;
    int li;
    if (!rst_n) begin
      init_cnt   = 0;
      exp_ready  = 0;
      exp_v      = 0;
      exp_choice = 1;
    end else if (exp_ready == 0) begin
      exp_v = 0;
      init_cnt++;
      if (init_cnt == 256) begin
        foreach (model_tbl[i]) model_tbl[i] = 1;
        exp_ready = 1;
      end
    end else begin
      exp_v = 0;
      if (upd_v) begin
        ui = pc_to_idx(upd_pc);
        if (upd_g && !upd_l && model_tbl[ui] < 3) model_tbl[ui] = model_tbl[ui] + 1;
        if (upd_l && !upd_g && model_tbl[ui] > 0) model_tbl[ui] = model_tbl[ui] - 1;
      end
      if (lookup_v) begin
        li = pc_to_idx(lookup_pc);
        exp_v      = 1;
        exp_choice = model_tbl[li];
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_choice_v", int'(choice_v), exp_v);
      check("cmp_choice", int'(choice), exp_choice);
      check("cmp_lookup_ready", int'(lookup_ready), exp_ready);
      check("cmp_upd_ready", int'(upd_ready), exp_ready);
      check("cmp_init_done", int'(init_done), exp_ready);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lookup_v  = 1'b0;
    lookup_pc = '0;
    upd_v     = 1'b0;
    upd_pc    = '0;
    upd_g     = 1'b0;
    upd_l     = 1'b0;
  endtask

  // Counts edges until init_done; stray requests in the first cycles must be ignored.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    lookup_v  = 1'b1;
    lookup_pc = 32'h100;
    upd_v     = 1'b1;
    upd_pc    = 32'h100;
    upd_g     = 1'b1;
    upd_l     = 1'b0;
    do begin
      step();
      n++;
      if (n == 200) clear_inputs();
    end while (!init_done && n < 1000);
    check(name, n, 256);
  endtask

  task automatic lookup_expect(input string name, input logic [31:0] pc, input int exp);
    lookup_v  = 1'b1;
    lookup_pc = pc;
    step();
    lookup_v = 1'b0;
    check({name, "_v"}, int'(choice_v), 1);
    check(name, int'(choice), exp);
  endtask

  task automatic update(input logic [31:0] pc, input logic g, input logic l);
    upd_v  = 1'b1;
    upd_pc = pc;
    upd_g  = g;
    upd_l  = l;
    step();
    upd_v = 1'b0;
  endtask

  initial begin
    int exp_g [4] = '{2, 3, 3, 3};
    int exp_l [4] = '{2, 1, 0, 0};
    clear_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_choice_v", int'(choice_v), 0);
    check("rst_choice", int'(choice), 1);
    check("rst_lookup_ready", int'(lookup_ready), 0);
    check("rst_upd_ready", int'(upd_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    step();
    step();
    rst_n = 1'b1;

    wait_init("init_len");
    lookup_expect("lk_0x100", 32'h100, 1);

    for (int i = 0; i < 4; i++) begin
      update(32'h40, 1'b1, 1'b0);
      lookup_expect($sformatf("glob_sat_%0d", i), 32'h40, exp_g[i]);
    end
    for (int i = 0; i < 4; i++) begin
      update(32'h40, 1'b0, 1'b1);
      lookup_expect($sformatf("loc_sat_%0d", i), 32'h40, exp_l[i]);
    end

    upd_v = 1'b1; upd_pc = 32'h80; upd_g = 1'b1; upd_l = 1'b1;
    check("agree_upd_ready", int'(upd_ready), 1);
    step();
    upd_v = 1'b0;
    lookup_expect("both_ok", 32'h80, 1);
    update(32'h80, 1'b0, 1'b0);
    lookup_expect("both_bad", 32'h80, 1);

    // Same-cycle update and lookup, then a neighbouring index in the same cycle.
    upd_v = 1'b1; upd_pc = 32'hC0; upd_g = 1'b1; upd_l = 1'b0;
    lookup_expect("bypass_c0", 32'hC0, 2);
    upd_v = 1'b0;
    upd_v = 1'b1; upd_pc = 32'hC0; upd_g = 1'b1; upd_l = 1'b0;
    lookup_expect("indep_c4", 32'hC4, 1);
    upd_v = 1'b0;
    lookup_expect("c0_after", 32'hC0, 3);

    // Back-to-back updates to one index must both count.
    update(32'h140, 1'b1, 1'b0);
    update(32'h140, 1'b1, 1'b0);
    lookup_expect("b2b_140", 32'h140, 3);
    update(32'h140, 1'b0, 1'b1);
    upd_v = 1'b1; upd_pc = 32'h140; upd_g = 1'b0; upd_l = 1'b1;
    lookup_expect("b2b_bypass_140", 32'h140, 1);
    upd_v = 1'b0;

    update(32'h0, 1'b1, 1'b0);
    update(32'h0, 1'b1, 1'b0);
    lookup_expect("alias_400", 32'h400, 3);

    // Mixed traffic on a few colliding PCs, checked by the model each cycle.
    for (int i = 0; i < 300; i++) begin
      lookup_v  = 1'($urandom_range(0, 1));
      lookup_pc = 32'h40 + 32'($urandom_range(0, 1)) * 32'h4 + 32'($urandom_range(0, 1)) * 32'h400;
      upd_v     = 1'($urandom_range(0, 1));
      upd_pc    = 32'h40 + 32'($urandom_range(0, 1)) * 32'h4 + 32'($urandom_range(0, 1)) * 32'h400;
      upd_g     = 1'($urandom_range(0, 1));
      upd_l     = 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();
    step();

    for (int i = 0; i < 3; i++) update(32'h40, 1'b1, 1'b0);
    lookup_expect("pre_rst_0x40", 32'h40, 3);
    lookup_v = 1'b1; lookup_pc = 32'h40;
    step();
    lookup_v = 1'b0;
    check("pre_rst_pulse", int'(choice_v), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_choice_v", int'(choice_v), 0);
    check("mid_rst_choice", int'(choice), 1);
    check("mid_rst_lookup_ready", int'(lookup_ready), 0);
    check("mid_rst_upd_ready", int'(upd_ready), 0);
    check("mid_rst_init_done", int'(init_done), 0);
    step();
    rst_n = 1'b1;
    wait_init("reinit_len");
    lookup_expect("post_rst_0x40", 32'h40, 1);
    lookup_expect("post_rst_0x100", 32'h100, 1);

    step();
    step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
